// File: rtl/branch_pkg.sv
// Shared branch types and constants for the fetch predictor and EX resolver.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_BEQ    = 3'd1,
    BR_BNE    = 3'd2,
    BR_BLT    = 3'd3,
    BR_BGE    = 3'h4,
    BR_BLTU   = 3'd5,
    BR_BGEU   = 3'd6,
    BR_DIRECT = 3'd7
  } br_type_e;

  // EX control code that is never allowed to branch.
  localparam logic [5:0] SUPPRESS_OP = 6'h27;

  // 2-bit saturating counter step.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit counters, one read port (fetch) and one
// update port (EX). Reads return the pre-update value in the update cycle.
module branch_bht #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);
  import branch_pkg::*;

  logic [1:0] ctr_q [DEPTH];

  // Counter array: weak not-taken after reset, saturating train on update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= sat_update(ctr_q[upd_idx], upd_taken);
    end
  end

  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_resolve_predict.sv
// Fetch-side taken/target prediction (BHT + tagged direct-mapped BTB) and
// EX-side branch resolution with a registered flush/redirect on mispredict.
//
// EX interface: ex_* inputs are meaningful only while ex_valid=1; each such
// cycle is consumed on the rising edge with no backpressure (no ready).
module branch_resolve_predict #(
  parameter int          XLEN        = 32,
  parameter int          BHT_DEPTH   = 64,
  parameter int          BTB_DEPTH   = 16,
  parameter int          TAG_W       = 8,
  parameter logic [5:0]  SUPPRESS_OP = branch_pkg::SUPPRESS_OP
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      ex_pc,
  input  branch_pkg::br_type_e branch_type,
  input  logic [5:0]           control_bus_ID_EX,
  input  logic                 alu_res,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  output logic                 branch_enable,
  output logic                 flush,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [31:0]          mispredict_cnt
);
  import branch_pkg::*;

  localparam int              BHT_IDX_W = $clog2(BHT_DEPTH);
  localparam int              BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  // BTB storage; only the valid bits need a reset.
  logic              btb_valid_q [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag_q   [BTB_DEPTH];
  logic [XLEN-1:0]   btb_tgt_q   [BTB_DEPTH];

  logic [BTB_IDX_W-1:0] if_btb_idx, ex_btb_idx;
  logic [TAG_W-1:0]     if_tag, ex_tag;
  logic                 if_btb_hit, ex_btb_hit;
  logic [1:0]           if_ctr;

  logic ctl_ok, cond_type, is_br, actual_taken, stale_hit, mispredict;
  logic [XLEN-1:0] correct_pc;

  assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
  assign if_tag     = if_pc[BTB_IDX_W+1+TAG_W:BTB_IDX_W+2];
  assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
  assign ex_tag     = ex_pc[BTB_IDX_W+1+TAG_W:BTB_IDX_W+2];

  assign if_btb_hit = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);
  assign ex_btb_hit = btb_valid_q[ex_btb_idx] && (btb_tag_q[ex_btb_idx] == ex_tag);

  branch_bht #(.DEPTH(BHT_DEPTH), .IDX_W(BHT_IDX_W)) u_bht (
    .clk       (clk),
    .rstn      (rstn),
    .rd_idx    (if_pc[BHT_IDX_W+1:2]),
    .rd_ctr    (if_ctr),
    .upd_en    (is_br),
    .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
    .upd_taken (actual_taken)
  );

  // Fetch prediction: needs both a BTB hit and a taken-leaning counter.
  always_comb begin
    pred_taken  = if_btb_hit && if_ctr[1];
    pred_target = pred_taken ? btb_tgt_q[if_btb_idx] : (if_pc + PC_STEP);
  end

  // EX resolution and mispredict detection.
  always_comb begin
    ctl_ok       = (control_bus_ID_EX != SUPPRESS_OP);
    cond_type    = (branch_type != BR_NONE) && (branch_type != BR_DIRECT);
    is_br        = ex_valid && (branch_type != BR_NONE) && ctl_ok;
    actual_taken = ex_valid && ctl_ok &&
                   ((cond_type && alu_res) || (branch_type == BR_DIRECT));
    // A non-branch predicted taken came from a stale BTB entry.
    stale_hit    = ex_valid && (branch_type == BR_NONE) && ex_pred_taken;
    mispredict   = stale_hit ||
                   (is_br && ((actual_taken != ex_pred_taken) ||
                              (actual_taken && ex_pred_taken && (ex_target != ex_pred_target))));
    correct_pc   = actual_taken ? ex_target : (ex_pc + PC_STEP);
    branch_enable = actual_taken;
  end

  // BTB valid bits: set on taken, dropped when a non-branch hits its entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb_valid_q[i] <= 1'b0;
    end else if (actual_taken) begin
      btb_valid_q[ex_btb_idx] <= 1'b1;
    end else if (ex_valid && (branch_type == BR_NONE) && ex_btb_hit) begin
      btb_valid_q[ex_btb_idx] <= 1'b0;
    end
  end

  // BTB tag/target payload written alongside the valid bit on taken.
  always_ff @(posedge clk) begin
    if (actual_taken) begin
      btb_tag_q[ex_btb_idx] <= ex_tag;
      btb_tgt_q[ex_btb_idx] <= ex_target;
    end
  end

  // Registered flush pulse and redirect target; redirect holds between flushes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) redirect_pc <= correct_pc;
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mispredict_cnt <= '0;
    end else if (mispredict && (mispredict_cnt != 32'hFFFF_FFFF)) begin
      mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule
